// File: rtl/health_alarm_manager.sv
// health_alarm_manager: debounces four detector flags into confirmed events,
// latches them as pending alarms, and presents them one at a time, in
// priority order, to the alert/display stage. Also drives a buzzer and keeps
// saturating event statistics.
//
// Handshake: alarmValid/alarmCode describe one alarm; alarmCode is stable for
// as long as alarmValid is high. The consumer raises alarmAck while
// alarmValid is high, and the alarm is retired on that rising edge.
// alarmValid then drops for the holdoff period. alarmAck has no effect while
// alarmValid is low.
module health_alarm_manager #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 8,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   presureAbnormality,
    input  logic                   bloodAbnormality,
    input  logic                   fallDetected,
    input  logic                   temperatureAbnormality,
    input  logic                   alarmAck,
    output logic                   alarmValid,
    output logic [1:0]             alarmCode,
    output logic [3:0]             pendingMask,
    output logic                   buzzer,
    output logic [COUNT_WIDTH-1:0] fallCount,
    output logic [COUNT_WIDTH-1:0] totalEvents
);

    localparam logic [3:0] DebMax   = 4'(DEBOUNCE_CYCLES);
    localparam logic [3:0] DebLast  = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] HoldLast = 8'(HOLDOFF_CYCLES - 1);
    localparam int         SumWidth = COUNT_WIDTH + 1;
    localparam logic [COUNT_WIDTH-1:0] CountMax = '1;

    // State is kept in a named enum so checkers can bind to it directly.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALERT   = 2'd1,
        HOLDOFF = 2'd2
    } stateT;

    stateT              state;
    stateT              stateNext;
    logic [7:0]         holdCnt;
    logic [7:0]         holdCntNext;
    logic [1:0]         codeNext;
    logic [1:0]         topCode;
    logic [3:0]         flags;
    logic [3:0]         confirm;
    logic [3:0]         ackClear;
    logic [2:0]         confirmCount;
    logic [SumWidth-1:0] totalSum;

    // Channel bits share the pendingMask ordering: {fall, pressure, blood, temp}.
    assign flags = {fallDetected, presureAbnormality, bloodAbnormality, temperatureAbnormality};

    for (genvar ch = 0; ch < 4; ch++) begin : gDebounce
        logic [3:0] debCnt;

        // Count consecutive high samples, holding at the threshold so a
        // flag that stays high confirms only once.
        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                debCnt <= '0;
            end else if (!flags[ch]) begin
                debCnt <= '0;
            end else if (debCnt != DebMax) begin
                debCnt <= debCnt + 4'd1;
            end
        end

        assign confirm[ch] = flags[ch] && (debCnt == DebLast);
    end

    // Highest-priority pending channel: fall > pressure > blood > temp.
    always_comb begin
        topCode = 2'b11;
        if (pendingMask[3]) begin
            topCode = 2'b00;
        end else if (pendingMask[2]) begin
            topCode = 2'b01;
        end else if (pendingMask[1]) begin
            topCode = 2'b10;
        end
    end

    // One-hot clear of the presented channel on an accepted acknowledge.
    always_comb begin
        ackClear = '0;
        if (state == ALERT && alarmAck) begin
            ackClear[2'd3 - alarmCode] = 1'b1;
        end
    end

    // Pending latch; a confirm on the same edge as a clear keeps the bit set.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pendingMask <= '0;
        end else begin
            pendingMask <= (pendingMask & ~ackClear) | confirm;
        end
    end

    // State, holdoff counter and latched code registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            holdCnt   <= '0;
            alarmCode <= '0;
        end else begin
            state     <= stateNext;
            holdCnt   <= holdCntNext;
            alarmCode <= codeNext;
        end
    end

    // Next-state logic: present, wait for acknowledge, then hold off.
    always_comb begin
        stateNext   = state;
        holdCntNext = holdCnt;
        codeNext    = alarmCode;
        case (state)
            IDLE: begin
                if (pendingMask != 4'b0000) begin
                    stateNext = ALERT;
                    codeNext  = topCode;
                end
            end
            ALERT: begin
                if (alarmAck) begin
                    stateNext   = HOLDOFF;
                    holdCntNext = '0;
                end
            end
            HOLDOFF: begin
                if (holdCnt == HoldLast) begin
                    stateNext = IDLE;
                end else begin
                    holdCntNext = holdCnt + 8'd1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Valid follows the state register, so asserting reset drops it at once.
    assign alarmValid = (state == ALERT);
    assign buzzer     = |pendingMask;

    assign confirmCount = 3'(confirm[0]) + 3'(confirm[1]) + 3'(confirm[2]) + 3'(confirm[3]);
    assign totalSum     = {1'b0, totalEvents} + SumWidth'(confirmCount);

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fallCount   <= '0;
            totalEvents <= '0;
        end else begin
            if (confirm[3] && fallCount != CountMax) begin
                fallCount <= fallCount + COUNT_WIDTH'(1);
            end
            if (totalSum > {1'b0, CountMax}) begin
                totalEvents <= CountMax;
            end else begin
                totalEvents <= totalSum[COUNT_WIDTH-1:0];
            end
        end
    end

endmodule
